aes_subkey_sequencer: RTL and testbench

Requester side of the AES key-schedule subkey interface. It walks the one-hot subkey_req vector forward for encryption and backward for decryption, and captures each returned 128-bit subkey when the echoed subkey_idx matches. It then hands the subkey to the round datapath over a valid/ready handshake, tagged with round number and first/last flags. It sits between the AES top-level control and aes_keyschedule.

---
 rtl/aes_subkey_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_aes_subkey_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subkey_sequencer.sv
// aes_subkey_sequencer
// Requester side of the AES key-schedule subkey interface. Walks a one-hot
// subkey request forward (encrypt) or backward (decrypt), captures each
// subkey when the echoed index matches, and hands it to the round datapath
// over a valid/ready handshake tagged with round number and first/last flags.
module aes_subkey_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         inv,
  input  logic [1:0]   aes_len,
  output logic [15:0]  subkey_req,
  input  logic [127:0] subkey_in,
  input  logic [15:0]  subkey_idx_in,
  output logic [127:0] rk,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   round,
  output logic         first_round,
  output logic         last_round,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_OUT,
    S_FIN,
    S_ERR
  } state_t;

  // Last counter value that still counts as "waiting"; reaching it without a
  // match ends the wait after exactly TIMEOUT_CYCLES request cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;

  logic [3:0]  idx;
  logic [3:0]  nr_q;
  logic        inv_q;
  logic [7:0]  tcnt;

  logic [3:0]  nr_sel;
  logic        len_ok;
  logic [15:0] req_vec;
  logic        hit;
  logic        timeout;
  logic [3:0]  first_idx;
  logic [3:0]  last_idx;

  // Decode the requested key length into the final round number.
  always_comb begin
    nr_sel = 4'd0;
    len_ok = 1'b1;
    case (aes_len)
      2'b01:   nr_sel = 4'd10;
      2'b10:   nr_sel = 4'd12;
      2'b11:   nr_sel = 4'd14;
      default: len_ok = 1'b0;
    endcase
  end

  // Request vector, match detection and sequence endpoints.
  always_comb begin
    req_vec   = 16'h0001 << idx;
    hit       = (state == S_REQ) && (subkey_idx_in == req_vec);
    timeout   = (state == S_REQ) && !hit && (tcnt == TO_LAST);
    first_idx = inv_q ? nr_q : 4'd0;
    last_idx  = inv_q ? 4'd0 : nr_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nxt  = state;
    subkey_req = '0;
    rk_valid   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = len_ok ? S_REQ : S_ERR;
        end
      end
      S_REQ: begin
        busy       = 1'b1;
        subkey_req = req_vec;
        if (hit) begin
          state_nxt = S_OUT;
        end else if (timeout) begin
          state_nxt = S_ERR;
        end
      end
      S_OUT: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        if (rk_ready) begin
          state_nxt = last_round ? S_FIN : S_REQ;
        end
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequence context, subkey capture, index stepping and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      nr_q        <= '0;
      inv_q       <= 1'b0;
      tcnt        <= '0;
      rk          <= '0;
      round       <= '0;
      first_round <= 1'b0;
      last_round  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && len_ok) begin
            inv_q <= inv;
            nr_q  <= nr_sel;
            idx   <= inv ? nr_sel : 4'd0;
            tcnt  <= '0;
          end
        end
        S_REQ: begin
          if (hit) begin
            rk          <= subkey_in;
            round       <= idx;
            first_round <= (idx == first_idx);
            last_round  <= (idx == last_idx);
          end else if (!timeout) begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_OUT: begin
          if (rk_ready && !last_round) begin
            idx  <= inv_q ? (idx - 4'd1) : (idx + 4'd1);
            tcnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky error: set on any entry to ERR, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (state == S_IDLE && start && len_ok) begin
      err <= 1'b0;
    end else if (state_nxt == S_ERR) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_subkey_sequencer.sv
// Testbench for aes_subkey_sequencer: an AES key-expansion model acts as the
// key schedule, and a scoreboard queue holds the expected round-key transfers.
module tb_aes_subkey_sequencer;

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
    logic         first;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         inv = 1'b0;
  logic [1:0]   aes_len = 2'b00;
  logic [15:0]  subkey_req;
  logic [127:0] subkey_in;
  logic [15:0]  subkey_idx_in;
  logic [127:0] rk;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [3:0]   round;
  logic         first_round;
  logic         last_round;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int failures = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rkeys [15];
  exp_t         exp_q [$];

  bit ks_echo = 1'b1;
  int ks_dly = 0;
  int ks_wait = 0;
  int ks_hit;

  logic [127:0] obs_rk_first, obs_rk_last;
  logic [3:0]   obs_rnd_first, obs_rnd_last;
  logic         obs_ff, obs_lf;
  int xfers, done_n, valid_n;

  aes_subkey_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv), .aes_len(aes_len),
    .subkey_req(subkey_req), .subkey_in(subkey_in), .subkey_idx_in(subkey_idx_in),
    .rk(rk), .rk_valid(rk_valid), .rk_ready(rk_ready), .round(round),
    .first_round(first_round), .last_round(last_round),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Key schedule model: answers after ks_dly cycles, showing zero or a
  // multi-hot index while it is "not ready".
  always @(posedge clk) begin
    if (subkey_req != 16'h0 && subkey_idx_in != subkey_req) ks_wait <= ks_wait + 1;
    else ks_wait <= 0;
  end

  always_comb begin
    ks_hit = 0;
    for (int i = 0; i < 16; i++) if (subkey_req[i]) ks_hit = i;
    subkey_idx_in = 16'h0;
    subkey_in     = {4{32'hdeadbeef}};
    if (subkey_req != 16'h0) begin
      if (ks_echo && ks_wait >= ks_dly) begin
        subkey_idx_in = subkey_req;
        subkey_in     = (ks_hit < 15) ? rkeys[ks_hit] : '0;
      end else begin
        subkey_idx_in = ks_wait[0] ? (subkey_req | 16'h8000) : 16'h0000;
      end
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  // Standard AES key expansion; key is left-aligned in 256 bits.
  task automatic expand_key(input logic [255:0] key, input logic [1:0] len);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = (len == 2'b01) ? 4 : (len == 2'b10) ? 6 : 8;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      rkeys[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Starts a sequence, fills the scoreboard, then serves rk_ready and checks
  // every transfer until done (or a mid-sequence reset at round rst_at).
  task automatic run_sequence(input bit inv_i, input logic [1:0] len_i, input int stall,
                              input int busy_at, input int rst_at, input bit fin_start);
    int nr, n, stall_cnt;
    bit injected;
    exp_t e;
    logic [127:0] h_rk;
    logic [3:0]   h_rnd;
    logic         h_f, h_l;
    nr = (len_i == 2'b01) ? 10 : (len_i == 2'b10) ? 12 : 14;
    exp_q.delete();
    for (int k = 0; k <= nr; k++) begin
      e.rnd   = 4'(inv_i ? nr - k : k);
      e.key   = rkeys[inv_i ? nr - k : k];
      e.first = (k == 0);
      e.last  = (k == nr);
      exp_q.push_back(e);
    end
    xfers = 0; done_n = -1; valid_n = -1; stall_cnt = 0; injected = 0; n = 0;
    h_rk = '0; h_rnd = '0; h_f = 1'b0; h_l = 1'b0;
    start = 1'b1; inv = inv_i; aes_len = len_i; rk_ready = (stall == 0);
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL start_accept: err=%b busy=%b, want err=0 busy=1", err, busy);
    end
    while (n < 400) begin
      if (done === 1'b1) begin done_n = n; break; end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL busy_held: busy=%b at cycle %0d, want 1", busy, n); end
      if (subkey_req !== 16'h0 && exp_q.size() > 0) begin
        checks++;
        if (subkey_req !== (16'h1 << exp_q[0].rnd)) begin
          failures++; $display("FAIL subkey_req: got %h want %h", subkey_req, 16'h1 << exp_q[0].rnd);
        end
      end
      if (rk_valid === 1'b1) begin
        if (valid_n < 0) valid_n = n;
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL extra_transfer: round=%0d, want none", round);
          break;
        end
        if (rst_at >= 0 && exp_q[0].rnd == 4'(rst_at)) begin
          rk_ready = 1'b0;
          #2 rst = 1'b0;
          #1;
          checks++;
          if ({subkey_req, rk, rk_valid, round, first_round, last_round, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL async_reset: req=%h rk=%h v=%b rnd=%0d f=%b l=%b busy=%b done=%b err=%b, want all 0",
                     subkey_req, rk, rk_valid, round, first_round, last_round, busy, done, err);
          end
          repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0) begin
              failures++; $display("FAIL reset_hold: done=%b busy=%b rk_valid=%b, want 0 0 0", done, busy, rk_valid);
            end
          end
          rst = 1'b1;
          exp_q.delete();
          return;
        end
        if (busy_at >= 0 && !injected && exp_q[0].rnd == 4'(busy_at)) begin
          start = 1'b1; inv = ~inv_i; aes_len = (len_i == 2'b01) ? 2'b11 : 2'b01; injected = 1;
        end
        if (stall_cnt == 0) begin
          h_rk = rk; h_rnd = round; h_f = first_round; h_l = last_round;
        end else begin
          checks++;
          if ({rk, round, first_round, last_round} !== {h_rk, h_rnd, h_f, h_l}) begin
            failures++; $display("FAIL stall_hold: rk=%h rnd=%0d, want rk=%h rnd=%0d held", rk, round, h_rk, h_rnd);
          end
        end
        if (stall_cnt < stall) begin
          rk_ready = 1'b0; stall_cnt++;
        end else begin
          rk_ready = 1'b1; stall_cnt = 0;
          e = exp_q.pop_front(); xfers++;
          checks++;
          if (round !== e.rnd || first_round !== e.first || last_round !== e.last) begin
            failures++; $display("FAIL xfer_tag: rnd=%0d f=%b l=%b, want rnd=%0d f=%b l=%b",
                                 round, first_round, last_round, e.rnd, e.first, e.last);
          end
          checks++;
          if (rk !== e.key) begin
            failures++; $display("FAIL xfer_rk: round %0d got %h want %h", e.rnd, rk, e.key);
          end
          if (e.first) begin obs_rk_first = rk; obs_rnd_first = round; obs_ff = first_round; end
          if (e.last)  begin obs_rk_last = rk;  obs_rnd_last = round;  obs_lf = last_round;  end
        end
      end else begin
        rk_ready = (stall == 0);
      end
      @(posedge clk); #1; n++;
      start = 1'b0;
    end
    if (done_n < 0) begin
      checks++; failures++; $display("FAIL seq_done_timeout: no done within 400 cycles, want done");
      return;
    end
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || subkey_req !== 16'h0 || exp_q.size() != 0) begin
      failures++; $display("FAIL fin_state: v=%b busy=%b req=%h left=%0d, want 0 0 0000 0",
                           rk_valid, busy, subkey_req, exp_q.size());
    end
    if (fin_start) begin start = 1'b1; inv = 1'b0; aes_len = 2'b01; end
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || subkey_req !== 16'h0) begin
      failures++; $display("FAIL done_one_cycle: done=%b busy=%b req=%h, want 0 0 0000", done, busy, subkey_req);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({subkey_req, rk, rk_valid, round, first_round, last_round, busy, done, err} !== '0) begin
      failures++; $display("FAIL reset_state: req=%h rk=%h v=%b busy=%b done=%b err=%b, want all 0",
                           subkey_req, rk, rk_valid, busy, done, err);
    end
    #20 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || subkey_req !== 16'h0) begin
      failures++; $display("FAIL reset_idle: busy=%b done=%b req=%h, want 0 0 0000", busy, done, subkey_req);
    end
  endtask

  task automatic test_aes128_fwd();
    expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'b01);
    checks++;
    if (rkeys[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      failures++; $display("FAIL model_aes128: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rkeys[10]);
    end
    run_sequence(1'b0, 2'b01, 0, -1, -1, 1'b1);
    checks++;
    if (xfers != 11 || valid_n != 1 || done_n != 22) begin
      failures++; $display("FAIL aes128_timing: xfers=%0d valid_at=%0d done_at=%0d, want 11 1 22", xfers, valid_n, done_n);
    end
    checks++;
    if (obs_rk_first !== 128'h2b7e151628aed2a6abf7158809cf4f3c || obs_rnd_first !== 4'd0 || obs_ff !== 1'b1) begin
      failures++; $display("FAIL aes128_first: rk=%h rnd=%0d f=%b, want 2b7e...4f3c 0 1", obs_rk_first, obs_rnd_first, obs_ff);
    end
    checks++;
    if (obs_rk_last !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || obs_rnd_last !== 4'd10 || obs_lf !== 1'b1) begin
      failures++; $display("FAIL aes128_last: rk=%h rnd=%0d l=%b, want d014...0ca6 10 1", obs_rk_last, obs_rnd_last, obs_lf);
    end
  endtask

  task automatic test_aes256_inv();
    expand_key(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 2'b11);
    run_sequence(1'b1, 2'b11, 0, -1, -1, 1'b0);
    checks++;
    if (xfers != 15 || done_n != 30) begin
      failures++; $display("FAIL aes256_count: xfers=%0d done_at=%0d, want 15 30", xfers, done_n);
    end
    checks++;
    if (obs_rk_first !== 128'hfe4890d1e6188d0b046df344706c631e || obs_rnd_first !== 4'd14 || obs_ff !== 1'b1) begin
      failures++; $display("FAIL aes256_first: rk=%h rnd=%0d f=%b, want fe48...631e 14 1", obs_rk_first, obs_rnd_first, obs_ff);
    end
    checks++;
    if (obs_rnd_last !== 4'd0 || obs_lf !== 1'b1) begin
      failures++; $display("FAIL aes256_last: rnd=%0d l=%b, want 0 1", obs_rnd_last, obs_lf);
    end
  endtask

  task automatic test_aes192_stall();
    expand_key({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 2'b10);
    ks_dly = 2;
    run_sequence(1'b0, 2'b10, 5, -1, -1, 1'b0);
    ks_dly = 0;
    checks++;
    if (xfers != 13 || obs_rnd_last !== 4'd12 || obs_rk_last !== 128'he98ba06f448c773c8ecc720401002202) begin
      failures++; $display("FAIL aes192_last: xfers=%0d rnd=%0d rk=%h, want 13 12 e98ba06f448c773c8ecc720401002202",
                           xfers, obs_rnd_last, obs_rk_last);
    end
  endtask

  task automatic test_timeout();
    ks_echo = 1'b0;
    start = 1'b1; inv = 1'b0; aes_len = 2'b01;
    @(posedge clk); #1; start = 1'b0;
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (subkey_req !== 16'h0001 || done !== 1'b0 || rk_valid !== 1'b0) begin
        failures++; $display("FAIL timeout_wait: cycle %0d req=%h done=%b v=%b, want 0001 0 0", n, subkey_req, done, rk_valid);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || rk_valid !== 1'b0 || subkey_req !== 16'h0) begin
      failures++; $display("FAIL timeout_err: done=%b err=%b v=%b req=%h, want 1 1 0 0000", done, err, rk_valid, subkey_req);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || err !== 1'b1) begin
      failures++; $display("FAIL timeout_sticky: done=%b err=%b, want 0 1", done, err);
    end
    ks_echo = 1'b1;
    expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'b01);
    run_sequence(1'b0, 2'b01, 0, -1, -1, 1'b0);
  endtask

  task automatic test_invalid_start();
    start = 1'b1; inv = 1'b0; aes_len = 2'b00;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || subkey_req !== 16'h0 || busy !== 1'b0) begin
      failures++; $display("FAIL invalid_err: done=%b err=%b req=%h busy=%b, want 1 1 0000 0", done, err, subkey_req, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || err !== 1'b1 || subkey_req !== 16'h0) begin
      failures++; $display("FAIL invalid_after: done=%b err=%b req=%h, want 0 1 0000", done, err, subkey_req);
    end
  endtask

  task automatic test_busy_and_reset();
    expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'b01);
    run_sequence(1'b0, 2'b01, 0, 3, 5, 1'b0);
    checks++;
    if (xfers != 5) begin
      failures++; $display("FAIL reset_xfers: got %0d transfers before reset, want 5", xfers);
    end
    run_sequence(1'b0, 2'b01, 0, -1, -1, 1'b0);
    checks++;
    if (xfers != 11 || done_n != 22) begin
      failures++; $display("FAIL after_reset_seq: xfers=%0d done_at=%0d, want 11 22", xfers, done_n);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_aes128_fwd();
    test_aes256_inv();
    test_aes192_stall();
    test_timeout();
    test_invalid_start();
    test_busy_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
